dotprod_engine: RTL and testbench

//  Parametrised dot-product accelerator: return_val = sum(a[i]*b[i]) for i = 0..n-1.
//  a/b operand banks are loaded over a write port; start/done handshake replaces free-running start.

---
 rtl/dotprod_engine.sv | 163 ++++++++++++++++
 tb/tb_dotprod_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotprod_engine.sv
// Dot-product engine: sums a[i]*b[i] over N loaded elements, LANES pairs per cycle,
// through a read -> multiply -> accumulate pipeline with optional saturation.
module dotprod_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LANES  = 1,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   n,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  return_val,
  output logic              ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AW1   = ADDR_W + 1;
  localparam int PW    = 2 * DATA_W + 1;
  localparam int BW    = (PW > ACC_W + 1) ? PW : ACC_W + 1;
  localparam int WW    = BW + $clog2(LANES) + 1;

  localparam logic [AW1-1:0]        DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [AW1-1:0]        STEP    = AW1'(LANES);
  localparam logic signed [WW-1:0]  ONE     = WW'(1);
  localparam logic signed [WW-1:0]  MAX_V   = (SIGNED != 0) ? (ONE <<< (ACC_W - 1)) - ONE
                                                            : (ONE <<< ACC_W) - ONE;
  localparam logic signed [WW-1:0]  MIN_V   = (SIGNED != 0) ? -(ONE <<< (ACC_W - 1)) : '0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  // Flat index row*LANES+lane is the same placement as per-lane banks of DEPTH/LANES rows
  logic [DATA_W-1:0]     mem_a [DEPTH];
  logic [DATA_W-1:0]     mem_b [DEPTH];

  logic [AW1-1:0]        n_lat, idx;
  logic [ADDR_W-1:0]     rd_addr [LANES];
  logic [LANES-1:0]      rd_msk, s1_msk;
  logic                  s1_vld, s2_vld, drained;
  logic [DATA_W-1:0]     s1_a [LANES];
  logic [DATA_W-1:0]     s1_b [LANES];
  logic signed [PW-1:0]  prod [LANES];
  logic signed [PW-1:0]  s2_prod [LANES];
  logic signed [WW-1:0]  sum;
  logic [ACC_W-1:0]      acc, acc_nxt;
  logic                  acc_ovf, step_ovf;

  function automatic logic signed [PW-1:0] widen(input logic [DATA_W-1:0] x);
    if (SIGNED != 0) return PW'($signed(x));
    return PW'(x);
  endfunction

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign drained = !s1_vld && !s2_vld;

  // A zero-length run passes through DRAIN so done lands one cycle after acceptance
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (n == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (idx + STEP >= n_lat) state_nxt = S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      rd_addr[l] = idx[ADDR_W-1:0] + ADDR_W'(l);
      rd_msk[l]  = (idx + AW1'(l)) < n_lat;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod[l] = s1_msk[l] ? widen(s1_a[l]) * widen(s1_b[l]) : '0;
    end
  end

  // Exact sum of accumulator and all lane products, then range-check against ACC_W
  always_comb begin
    if (SIGNED != 0) sum = WW'($signed(acc));
    else             sum = WW'(acc);
    for (int unsigned l = 0; l < LANES; l++) begin
      sum = sum + WW'(s2_prod[l]);
    end
    step_ovf = 1'b0;
    acc_nxt  = sum[ACC_W-1:0];
    if (sum > MAX_V) begin
      step_ovf = 1'b1;
      if (SAT != 0) acc_nxt = MAX_V[ACC_W-1:0];
    end else if (sum < MIN_V) begin
      step_ovf = 1'b1;
      if (SAT != 0) acc_nxt = MIN_V[ACC_W-1:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en && !busy) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      s1_a[l]    <= mem_a[rd_addr[l]];
      s1_b[l]    <= mem_b[rd_addr[l]];
      s2_prod[l] <= prod[l];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      n_lat      <= '0;
      idx        <= '0;
      s1_vld     <= 1'b0;
      s1_msk     <= '0;
      s2_vld     <= 1'b0;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      return_val <= '0;
      ovf        <= 1'b0;
    end else begin
      s1_vld <= (state == S_RUN);
      s1_msk <= rd_msk;
      s2_vld <= s1_vld;
      case (state)
        S_IDLE: if (start) begin
          n_lat   <= (n > DEPTH_N) ? DEPTH_N : n;
          idx     <= '0;
          acc     <= '0;
          acc_ovf <= 1'b0;
        end
        S_RUN: idx <= idx + STEP;
        S_DRAIN: if (drained) begin
          return_val <= acc;
          ovf        <= acc_ovf;
        end
        default: ;
      endcase
      if (s2_vld) begin
        acc     <= acc_nxt;
        acc_ovf <= acc_ovf | step_ovf;
      end
    end
  end

endmodule

// File: tb/tb_dotprod_engine.sv
// Scoreboard bench for dotprod_engine: four configurations share one stimulus stream,
// each checked against an arithmetic reference model of the dot product.
module tb_dotprod_engine;

  localparam int NDUT = 4;
  localparam int LN [NDUT] = '{1, 4, 2, 8};
  localparam bit SG [NDUT] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit ST [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic        sys_clk, sys_rst_n;
  logic        wr_en, wr_sel, start;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  n;
  logic [NDUT-1:0] busy, done, ovf;
  logic [31:0] rv [NDUT];

  logic [31:0] sa [16];
  logic [31:0] sb [16];
  exp_t        q [NDUT][$];
  exp_t        mon_e;
  int unsigned cyc;
  int          n_checks, n_pass;

  dotprod_engine #(.DATA_W(32), .ADDR_W(4), .LANES(1), .ACC_W(32), .SIGNED(0), .SAT(0)) u_d0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .n(n), .busy(busy[0]), .done(done[0]), .return_val(rv[0]), .ovf(ovf[0]));
  dotprod_engine #(.DATA_W(32), .ADDR_W(4), .LANES(4), .ACC_W(32), .SIGNED(1), .SAT(1)) u_d1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .n(n), .busy(busy[1]), .done(done[1]), .return_val(rv[1]), .ovf(ovf[1]));
  dotprod_engine #(.DATA_W(32), .ADDR_W(4), .LANES(2), .ACC_W(32), .SIGNED(1), .SAT(0)) u_d2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .n(n), .busy(busy[2]), .done(done[2]), .return_val(rv[2]), .ovf(ovf[2]));
  dotprod_engine #(.DATA_W(32), .ADDR_W(4), .LANES(8), .ACC_W(32), .SIGNED(0), .SAT(1)) u_d3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .n(n), .busy(busy[3]), .done(done[3]), .return_val(rv[3]), .ovf(ovf[3]));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic signed [127:0] ext(input logic [31:0] x, input bit sgn);
    if (sgn) return {{96{x[31]}}, x};
    return {96'b0, x};
  endfunction

  // Reference: groups of `lanes` elements are added to the running sum, which is
  // range-checked after every group and then clamped or wrapped.
  function automatic logic [32:0] model(input int lanes, input bit sgn, input bit sat, input int nn);
    logic signed [127:0] acc, mx, mn;
    int  cnt;
    bit  o;
    cnt = (nn > 16) ? 16 : nn;
    o   = 1'b0;
    acc = '0;
    mx  = sgn ? 128'sh7FFF_FFFF : 128'shFFFF_FFFF;
    mn  = sgn ? -128'sh8000_0000 : 128'sh0;
    for (int g = 0; g * lanes < cnt; g++) begin
      for (int l = 0; l < lanes; l++) begin
        if (g * lanes + l < cnt) acc = acc + ext(sa[g * lanes + l], sgn) * ext(sb[g * lanes + l], sgn);
      end
      if (acc > mx || acc < mn) begin
        o = 1'b1;
        if (sat) acc = (acc > mx) ? mx : mn;
        else     acc = ext(acc[31:0], sgn);
      end
    end
    return {o, acc[31:0]};
  endfunction

  task automatic expect_run(input int nn, input int unsigned e0);
    logic [32:0] r;
    exp_t e;
    int cnt, g;
    cnt = (nn > 16) ? 16 : nn;
    for (int k = 0; k < NDUT; k++) begin
      r     = model(LN[k], SG[k], ST[k], nn);
      g     = (cnt + LN[k] - 1) / LN[k];
      e.val = r[31:0];
      e.ovf = r[32];
      e.cyc = (cnt == 0) ? e0 + 1 : e0 + 32'(g) + 3;
      q[k].push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit empty;
    for (int t = 0; t < 100; t++) begin
      empty = 1'b1;
      for (int k = 0; k < NDUT; k++) if (q[k].size() != 0) empty = 1'b0;
      if (empty) break;
      @(negedge sys_clk);
    end
    for (int k = 0; k < NDUT; k++) begin
      if (q[k].size() != 0) begin
        check($sformatf("timeout_d%0d pending", k), 64'(q[k].size()), 64'd0);
        q[k].delete();
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic wr(input bit sel, input int addr, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    if (sel) sb[addr] = d;
    else     sa[addr] = d;
    @(negedge sys_clk);
    wr_en = 1'b0;
  endtask

  // inject: extra start pulses and a write to a[0] while the run is in flight
  task automatic run(input int nn, input bit inject);
    start = 1'b1;
    n     = 5'(nn);
    expect_run(nn, cyc + 1);
    @(negedge sys_clk);
    start = 1'b0;
    if (inject) begin
      repeat (2) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd0;
        wr_data = ~sa[0];
        @(negedge sys_clk);
      end
      start = 1'b0;
      wr_en = 1'b0;
    end
    wait_idle();
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 15));
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = 32'hFFFF_FFFF;
    endcase
    return v;
  endfunction

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      for (int k = 0; k < NDUT; k++) begin
        if (done[k]) begin
          if (q[k].size() == 0) begin
            check($sformatf("spurious_done_d%0d", k), 64'(done[k]), 64'd0);
          end else begin
            mon_e = q[k].pop_front();
            check($sformatf("result_d%0d", k), 64'(rv[k]), 64'(mon_e.val));
            check($sformatf("ovf_d%0d", k), 64'(ovf[k]), 64'(mon_e.ovf));
            check($sformatf("latency_d%0d", k), 64'(cyc), 64'(mon_e.cyc));
          end
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    sys_rst_n = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; n = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    for (int k = 0; k < NDUT; k++) check($sformatf("reset_rv_d%0d", k), 64'(rv[k]), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, rnd_val());
      wr(1'b1, i, rnd_val());
    end

    // basic four-element product: 1*5+2*6+3*7+4*8
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, 32'(i + 1));
      wr(1'b1, i, 32'(i + 5));
    end
    run(4, 1'b0);
    for (int k = 0; k < NDUT; k++) check($sformatf("t1_rv_d%0d", k), 64'(rv[k]), 64'd70);
    check("t1_ovf", 64'(ovf), 64'd0);

    // reset mid-run: outputs clear at once, aborted run never completes
    start = 1'b1;
    n     = 5'd4;
    @(negedge sys_clk);
    start = 1'b0;
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    for (int k = 0; k < NDUT; k++) check($sformatf("t6_rv_d%0d", k), 64'(rv[k]), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run(4, 1'b0);
    for (int k = 0; k < NDUT; k++) check($sformatf("t6_rerun_d%0d", k), 64'(rv[k]), 64'd70);

    // zero-length run
    start = 1'b1;
    n     = 5'd0;
    expect_run(0, cyc + 1);
    @(negedge sys_clk);
    start = 1'b0;
    check("t2_busy_c1", 64'(busy), 64'hF);
    check("t2_done_c1", 64'(done), 64'h0);
    @(negedge sys_clk);
    check("t2_busy_c2", 64'(busy), 64'hF);
    check("t2_done_c2", 64'(done), 64'hF);
    @(negedge sys_clk);
    check("t2_busy_c3", 64'(busy), 64'h0);
    for (int k = 0; k < NDUT; k++) check($sformatf("t2_rv_d%0d", k), 64'(rv[k]), 64'd0);
    wait_idle();

    // partial last group; elements 6 and 7 hold nonzero data that must be masked
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, i, 32'(i + 1));
      wr(1'b1, i, 32'd2);
    end
    run(6, 1'b0);
    for (int k = 0; k < NDUT; k++) check($sformatf("t3_rv_d%0d", k), 64'(rv[k]), 64'd42);

    // overflow: each product already exceeds the 32-bit range
    for (int i = 0; i < 2; i++) begin
      wr(1'b0, i, 32'h7FFF_FFFF);
      wr(1'b1, i, 32'h7FFF_FFFF);
    end
    run(2, 1'b0);
    check("t4_wrap_u", 64'(rv[0]), 64'd2);
    check("t4_sat_s", 64'(rv[1]), 64'h7FFF_FFFF);
    check("t4_wrap_s", 64'(rv[2]), 64'd2);
    check("t4_sat_u", 64'(rv[3]), 64'hFFFF_FFFF);
    check("t4_ovf", 64'(ovf), 64'hF);

    // start pulses and writes during a full-depth run are ignored
    wr(1'b0, 0, 32'd3);
    run(16, 1'b1);
    run(16, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int nn;
      repeat ($urandom_range(0, 4)) wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd_val());
      nn = int'($urandom_range(0, 20));
      run(nn, (nn > 0) && ($urandom_range(0, 3) == 0));
    end

    for (int k = 0; k < NDUT; k++) check($sformatf("final_queue_d%0d", k), 64'(q[k].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
